mux_scan_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. Successor of the 4:1 combinational mux.
- Adds direct, auto-scan and hold modes.
- Adds a channel-enable mask, a configurable dwell time and output-valid/wrap flags.
- Sits between the input-sampling blocks and the display/serialiser path. It lets one consumer observe several sources in turn.

---
 rtl/mux_scan_n_pkg.sv | 26 ++
 rtl/mux_scan_n_rr_next_idx.sv | 29 ++
 rtl/mux_scan_n.sv | 146 ++++++++++++++
 tb/tb_mux_scan_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_n_pkg.sv
// Shared encodings for the scanning multiplexer: mode inputs and FSM states.
// The FSM state simply follows the mode input each cycle.
package mux_scan_n_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    localparam logic [1:0] ST_DIRECT = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // The reserved mode behaves as hold.
    function automatic logic [1:0] mode_to_state(input logic [1:0] mode_v);
        logic [1:0] st_v;
        case (mode_v)
            MODE_DIRECT: st_v = ST_DIRECT;
            MODE_SCAN:   st_v = ST_SCAN;
            MODE_HOLD:   st_v = ST_HOLD;
            default:     st_v = ST_HOLD;
        endcase
        return st_v;
    endfunction

endpackage

// File: rtl/mux_scan_n_rr_next_idx.sv
// Circular "next enabled index strictly after cur_i" search over an N-bit mask.
// Purely combinational; cur_i must be < N. A lone enabled bit equal to cur_i returns cur_i.
module rr_next_idx #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [SW-1:0] cur_i,
    input  logic [N-1:0]  mask_i,
    output logic [SW-1:0] next_o,
    output logic          found_o,
    output logic          wrapped_o
);

    // Lowest circular offset with an enabled bit wins.
    always_comb begin
        int  t;
        logic hit;
        next_o  = cur_i;
        found_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            t       = (int'(cur_i) + k) % N;
            hit     = ~found_o & mask_i[t];
            next_o  = hit ? SW'(t) : next_o;
            found_o = found_o | hit;
        end
        wrapped_o = found_o & (next_o <= cur_i);
    end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with direct, auto-scan and hold modes,
// a scan enable mask, per-channel dwell time and valid/wrap flags.
module mux_scan_n
    import mux_scan_n_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 1,
    localparam int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] in_bus,
    input  logic [SW-1:0]  sel,
    input  logic [1:0]     mode,
    input  logic [N-1:0]   en_mask,
    output logic [W-1:0]   out,
    output logic [SW-1:0]  out_ch,
    output logic           valid,
    output logic           wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [W-1:0]  out_q,    out_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          valid_q,  valid_d;
    logic          wrap_q,   wrap_d;
    logic [SW-1:0] ptr_q,    ptr_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [1:0]    state_q,  state_d;
    logic          fresh_q,  fresh_d;

    logic          sel_ok_s, ptr_ok_s, ptr_en_s, entry_s, adv_s;
    logic [SW-1:0] ptr_base_s, rr_next_s, nxt_s;
    logic          rr_found_s, rr_wrapped_s, nxt_wrap_s;
    logic [W-1:0]  dir_data_s, scan_data_s;

    // A direct sel >= N can leave ptr out of range; search from N-1 so scan restarts at ch0.
    assign sel_ok_s   = (int'(sel) < N);
    assign ptr_ok_s   = (int'(ptr_q) < N);
    assign ptr_base_s = ptr_ok_s ? ptr_q : SW'(N - 1);
    assign ptr_en_s   = ptr_ok_s & en_mask[ptr_base_s];
    assign entry_s    = (state_q == ST_DIRECT) | fresh_q;
    assign adv_s      = (cnt_q == CW'(DWELL - 1));

    rr_next_idx #(.N(N), .SW(SW)) u_next (
        .cur_i     (ptr_base_s),
        .mask_i    (en_mask),
        .next_o    (rr_next_s),
        .found_o   (rr_found_s),
        .wrapped_o (rr_wrapped_s)
    );

    // Pick the channel shown this scan cycle: entry fix-up, dwell advance, or stay.
    always_comb begin
        nxt_s      = ptr_q;
        nxt_wrap_s = 1'b0;
        if (entry_s) begin
            nxt_s = ptr_en_s ? ptr_q : rr_next_s;
        end else if (adv_s) begin
            nxt_s      = rr_next_s;
            nxt_wrap_s = rr_wrapped_s;
        end else begin
            nxt_s = ptr_q;
        end
    end

    // Channel data multiplexers for direct and scan paths.
    always_comb begin
        dir_data_s  = '0;
        scan_data_s = '0;
        for (int i = 0; i < N; i++) begin
            dir_data_s  = (sel   == SW'(i)) ? in_bus[i*W +: W] : dir_data_s;
            scan_data_s = (nxt_s == SW'(i)) ? in_bus[i*W +: W] : scan_data_s;
        end
    end

    // Next-state logic; fresh_q forces the entry rule after DIRECT or an empty mask.
    always_comb begin
        state_d  = mode_to_state(mode);
        out_d    = out_q;
        out_ch_d = out_ch_q;
        valid_d  = valid_q;
        wrap_d   = 1'b0;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        fresh_d  = fresh_q;
        case (state_d)
            ST_DIRECT: begin
                out_d    = sel_ok_s ? dir_data_s : '0;
                out_ch_d = sel;
                valid_d  = sel_ok_s;
                ptr_d    = sel;
                cnt_d    = '0;
                fresh_d  = 1'b1;
            end
            ST_SCAN: begin
                if (!rr_found_s) begin
                    valid_d = 1'b0;
                    fresh_d = 1'b1;
                end else begin
                    ptr_d    = nxt_s;
                    out_d    = scan_data_s;
                    out_ch_d = nxt_s;
                    valid_d  = 1'b1;
                    wrap_d   = nxt_wrap_s;
                    fresh_d  = 1'b0;
                    cnt_d    = (entry_s | adv_s) ? '0 : cnt_q + CW'(1);
                end
            end
            default: begin
                wrap_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_DIRECT;
            fresh_q  <= 1'b1;
        end else begin
            out_q    <= out_d;
            out_ch_q <= out_ch_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            fresh_q  <= fresh_d;
        end
    end

    assign out    = out_q;
    assign out_ch = out_ch_q;
    assign valid  = valid_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a cycle model checked on every negedge for the
// N=4 instance, plus literal expectations for both the N=4 and N=3 instances.
module tb_mux_scan_n;

    localparam int DW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_bus4;
    logic [1:0]  sel4, mode4;
    logic [3:0]  mask4;
    logic [7:0]  out4;
    logic [1:0]  ch4;
    logic        valid4, wrap4;

    logic [11:0] in_bus3;
    logic [1:0]  sel3, mode3;
    logic [2:0]  mask3;
    logic [3:0]  out3;
    logic [1:0]  ch3;
    logic        valid3, wrap3;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mux_scan_n #(.N(4), .W(8), .DWELL(DW)) u4 (
        .clk(clk), .reset(rst), .in_bus(in_bus4), .sel(sel4), .mode(mode4),
        .en_mask(mask4), .out(out4), .out_ch(ch4), .valid(valid4), .wrap(wrap4)
    );

    mux_scan_n #(.N(3), .W(4), .DWELL(DW)) u3 (
        .clk(clk), .reset(rst), .in_bus(in_bus3), .sel(sel3), .mode(mode3),
        .en_mask(mask3), .out(out3), .out_ch(ch3), .valid(valid3), .wrap(wrap3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of the N=4 instance: shown counts cycles spent on the current channel.
    int         m_ptr, m_shown;
    bit         m_fresh;
    logic [7:0] exp_out;
    logic [1:0] exp_ch;
    logic       exp_valid, exp_wrap;

    function automatic logic [7:0] chan(input int p);
        return 8'((p + 1) * 17);
    endfunction

    function automatic int next_en(input int p, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    task model_step();
        int n;
        if (rst) begin
            exp_out = 8'h00; exp_ch = 2'd0; exp_valid = 1'b0; exp_wrap = 1'b0;
            m_ptr = 0; m_shown = 0; m_fresh = 1'b1;
        end else begin
            exp_wrap = 1'b0;
            if (mode4 == 2'b00) begin
                m_ptr = int'(sel4); m_shown = 0; m_fresh = 1'b1;
                exp_ch = sel4; exp_valid = 1'b1; exp_out = chan(m_ptr);
            end else if (mode4 == 2'b01) begin
                if (mask4 == 4'b0000) begin
                    exp_valid = 1'b0; m_fresh = 1'b1;
                end else begin
                    if (m_fresh) begin
                        if (!mask4[m_ptr]) m_ptr = next_en(m_ptr, mask4);
                        m_shown = 1; m_fresh = 1'b0;
                    end else if (m_shown >= DW) begin
                        n = next_en(m_ptr, mask4);
                        exp_wrap = (n <= m_ptr);
                        m_ptr = n; m_shown = 1;
                    end else begin
                        m_shown++;
                    end
                    exp_ch = m_ptr[1:0]; exp_valid = 1'b1; exp_out = chan(m_ptr);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_out",   32'(out4),   32'(exp_out));
            chk("m_ch",    32'(ch4),    32'(exp_ch));
            chk("m_valid", 32'(valid4), 32'(exp_valid));
            chk("m_wrap",  32'(wrap4),  32'(exp_wrap));
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] t2_out [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11};
    logic [7:0] t3_out [5] = '{8'h22, 8'h22, 8'h44, 8'h44, 8'h22};
    logic [1:0] t6_ch  [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

    initial begin
        in_bus4 = {8'h44, 8'h33, 8'h22, 8'h11};
        in_bus3 = {4'hC, 4'hB, 4'hA};
        rst = 1'b1; sel4 = 2'd0; mode4 = 2'b00; mask4 = 4'b0000;
        sel3 = 2'd0; mode3 = 2'b10; mask3 = 3'b000;
        cmp_en = 1'b1;
        tick();
        chk("rst_out", 32'(out4), 32'h0);
        chk("rst_valid", 32'(valid4), 32'h0);
        rst = 1'b0;

        // 1: direct select, then reset clears outputs
        mode4 = 2'b00; sel4 = 2'd2; tick();
        chk("t1_out", 32'(out4), 32'h33);
        chk("t1_ch", 32'(ch4), 32'h2);
        chk("t1_valid", 32'(valid4), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t1_rst_out", 32'(out4), 32'h0);
        chk("t1_rst_valid", 32'(valid4), 32'h0);

        // 2: full-mask scan from ch0
        sel4 = 2'd0; tick();
        mode4 = 2'b01; mask4 = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t2_out", 32'(out4), 32'(t2_out[i]));
            chk("t2_wrap", 32'(wrap4), (i == 8) ? 32'h1 : 32'h0);
        end

        // 3: sparse mask, ch0 skipped on entry
        mode4 = 2'b00; sel4 = 2'd0; tick();
        mode4 = 2'b01; mask4 = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_out", 32'(out4), 32'(t3_out[i]));
            chk("t3_wrap", 32'(wrap4), (i == 4) ? 32'h1 : 32'h0);
        end

        // 4: empty mask stalls, restored mask re-enters
        mask4 = 4'b0000; tick(); tick();
        chk("t4_valid0", 32'(valid4), 32'h0);
        chk("t4_frozen", 32'(out4), 32'h22);
        mask4 = 4'b0100; tick();
        chk("t4_out", 32'(out4), 32'h33);
        chk("t4_ch", 32'(ch4), 32'h2);
        chk("t4_valid1", 32'(valid4), 32'h1);

        // 5: hold mid-dwell keeps the counter
        mode4 = 2'b00; sel4 = 2'd1; tick();
        mode4 = 2'b01; mask4 = 4'b1111; tick();
        mode4 = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_out", 32'(out4), 32'h22);
        end
        mode4 = 2'b01; tick();
        chk("t5_again", 32'(out4), 32'h22);
        tick();
        chk("t5_next", 32'(out4), 32'h33);

        // mask change mid-dwell, then a single enabled channel
        mask4 = 4'b1011; tick();
        chk("mc_finish", 32'(ch4), 32'h2);
        tick();
        chk("mc_adv", 32'(ch4), 32'h3);
        mask4 = 4'b0001;
        for (int i = 0; i < 6; i++) tick();

        // mid-scan reset, reserved mode holds
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_ch", 32'(ch4), 32'h0);
        mask4 = 4'b1111; tick(); tick(); tick();
        mode4 = 2'b11; tick(); tick();
        mode4 = 2'b00; sel4 = 2'd3; tick();

        // 6: N=3 instance, illegal direct sel then scan
        mode3 = 2'b00; sel3 = 2'd3; tick();
        chk("t6_valid", 32'(valid3), 32'h0);
        chk("t6_out", 32'(out3), 32'h0);
        mode3 = 2'b01; mask3 = 3'b111;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t6_ch", 32'(ch3), 32'(t6_ch[i]));
            chk("t6_out_s", 32'(out3), 32'h0A + 32'(t6_ch[i]));
        end
        chk("t6_wrap", 32'(wrap3), 32'h1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
